contador15_ctrl: RTL and testbench

//   Control stage downstream of the clock divider in the contador15 design.

---
 rtl/contador15_ctrl.sv | 139 +++++++++++++
 tb/tb_contador15_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/contador15_ctrl.sv
// Start/stop/clear up/down counter with a hex 7-segment digit, advanced by rising
// edges of a slow tick wave that is sampled in the clock_in domain.
module contador15_ctrl #(
    parameter int WIDTH          = 4,
    parameter int MAX_COUNT      = 15,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             up_down,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] count,
    output logic [6:0]       seg,
    output logic             terminal,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             terminal_reg, terminal_next;
    logic             running_reg, done_reg;
    logic             tick_q_reg, tick_qq_reg;
    logic             tick_edge;
    logic [WIDTH-1:0] limit_value, load_value;
    logic [3:0]       digit;
    logic [6:0]       seg_on;

    assign tick_edge   = tick_q_reg & ~tick_qq_reg;
    assign limit_value = up_down ? MAX_V : '0;
    assign load_value  = up_down ? '0 : MAX_V;

    // Priority: clear > stop > start > tick_edge. A start while already running is a
    // no-op, so a tick in that cycle still counts.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        terminal_next = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
            count_next = load_value;
        end else if (stop) begin
            if (state_reg == ST_RUN) begin
                state_next = ST_PAUSE;
            end
        end else if (start && (state_reg != ST_RUN)) begin
            state_next = ST_RUN;
            if (state_reg == ST_DONE) begin
                count_next = load_value;
            end
        end else if ((state_reg == ST_RUN) && tick_edge) begin
            if (count_reg == limit_value) begin
                terminal_next = 1'b1;
                if (wrap_en) begin
                    count_next = load_value;
                end else begin
                    state_next = ST_DONE;
                end
            end else if (up_down) begin
                count_next = count_reg + ONE_V;
            end else begin
                count_next = count_reg - ONE_V;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            terminal_reg <= 1'b0;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
            tick_q_reg   <= 1'b0;
            tick_qq_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            terminal_reg <= terminal_next;
            running_reg  <= (state_next == ST_RUN);
            done_reg     <= (state_next == ST_DONE);
            tick_q_reg   <= tick_in;
            tick_qq_reg  <= tick_q_reg;
        end
    end

    generate
        if (WIDTH >= 4) begin : g_digit_wide
            assign digit = count_reg[3:0];
        end else begin : g_digit_narrow
            assign digit = {{(4 - WIDTH){1'b0}}, count_reg};
        end
    endgenerate

    // Segment order is {g,f,e,d,c,b,a}, active-high here; polarity applied below.
    always_comb begin
        seg_on = 7'b0000000;
        case (digit)
            4'h0: seg_on = 7'b0111111;
            4'h1: seg_on = 7'b0000110;
            4'h2: seg_on = 7'b1011011;
            4'h3: seg_on = 7'b1001111;
            4'h4: seg_on = 7'b1100110;
            4'h5: seg_on = 7'b1101101;
            4'h6: seg_on = 7'b1111101;
            4'h7: seg_on = 7'b0000111;
            4'h8: seg_on = 7'b1111111;
            4'h9: seg_on = 7'b1101111;
            4'hA: seg_on = 7'b1110111;
            4'hB: seg_on = 7'b1111100;
            4'hC: seg_on = 7'b0111001;
            4'hD: seg_on = 7'b1011110;
            4'hE: seg_on = 7'b1111001;
            4'hF: seg_on = 7'b1110001;
            default: seg_on = 7'b0000000;
        endcase
    end

    assign seg      = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    assign count    = count_reg;
    assign terminal = terminal_reg;
    assign running  = running_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_contador15_ctrl.sv
// Directed bench for contador15_ctrl: a cycle-level behavioural model checked every
// clock, plus literal expectations for the scenarios that pin the model down.
module tb_contador15_ctrl;

    localparam int MAXC = 15;

    logic       clock_in = 1'b0;
    logic       reset    = 1'b1;
    logic       tick_in  = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       clear    = 1'b0;
    logic       up_down  = 1'b1;
    logic       wrap_en  = 1'b1;
    logic [3:0] count;
    logic [6:0] seg;
    logic       terminal;
    logic       running;
    logic       done;

    int total = 0;
    int bad   = 0;
    int term_seen = 0;
    bit checks_on = 1'b0;

    contador15_ctrl #(.WIDTH(4), .MAX_COUNT(MAXC), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .tick_in  (tick_in),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .up_down  (up_down),
        .wrap_en  (wrap_en),
        .count    (count),
        .seg      (seg),
        .terminal (terminal),
        .running  (running),
        .done     (done)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp, input bit verbose);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else if (verbose) begin
            $display("check %s ok: %0d", name, act);
        end
    endtask

    // Plain hexadecimal seven-segment table, {g..a}, then common-anode inversion.
    function automatic logic [6:0] hex_seg(input int v);
        logic [6:0] s;
        case (v)
            0: s = 7'h3F;  1: s = 7'h06;  2: s = 7'h5B;  3: s = 7'h4F;
            4: s = 7'h66;  5: s = 7'h6D;  6: s = 7'h7D;  7: s = 7'h07;
            8: s = 7'h7F;  9: s = 7'h6F; 10: s = 7'h77; 11: s = 7'h7C;
            12: s = 7'h39; 13: s = 7'h5E; 14: s = 7'h79; default: s = 7'h71;
        endcase
        return ~s;
    endfunction

    // Behavioural model: the counter as an integer, the mode as a small enumeration.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode, m_cnt;
    bit m_term, m_prev1, m_prev2;

    always @(posedge clock_in or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_cnt = 0; m_term = 0; m_prev1 = 0; m_prev2 = 0;
        end else begin
            bit rise;
            int lim, load;
            rise = m_prev1 && !m_prev2;
            m_prev2 = m_prev1;
            m_prev1 = tick_in;
            lim  = up_down ? MAXC : 0;
            load = up_down ? 0 : MAXC;
            m_term = 0;
            if (clear) begin
                m_mode = M_IDLE; m_cnt = load;
            end else if (stop) begin
                if (m_mode == M_RUN) m_mode = M_PAUSE;
            end else if (start && m_mode != M_RUN) begin
                if (m_mode == M_DONE) m_cnt = load;
                m_mode = M_RUN;
            end else if (m_mode == M_RUN && rise) begin
                if (m_cnt == lim) begin
                    m_term = 1;
                    if (wrap_en) m_cnt = load;
                    else m_mode = M_DONE;
                end else begin
                    m_cnt = up_down ? m_cnt + 1 : m_cnt - 1;
                end
            end
        end
    end

    always @(posedge clock_in) begin
        #1;
        if (terminal === 1'b1) term_seen++;
        if (checks_on && !reset) begin
            chk("model_count", int'(count), m_cnt, 1'b0);
            chk("model_seg", int'(seg), int'(hex_seg(m_cnt)), 1'b0);
            chk("model_terminal", int'(terminal), int'(m_term), 1'b0);
            chk("model_running", int'(running), int'(m_mode == M_RUN), 1'b0);
            chk("model_done", int'(done), int'(m_mode == M_DONE), 1'b0);
        end
    end

    task automatic tick_pulse();
        @(negedge clock_in) tick_in = 1'b1;
        @(negedge clock_in);
        @(negedge clock_in) tick_in = 1'b0;
        @(negedge clock_in);
        @(negedge clock_in);
    endtask

    task automatic do_start();
        @(negedge clock_in) start = 1'b1;
        @(negedge clock_in) start = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clock_in) clear = 1'b1;
        @(negedge clock_in) clear = 1'b0;
    endtask

    initial begin
        int t0;
        #3;
        chk("reset_count", int'(count), 0, 1'b1);
        chk("reset_seg", int'(seg), 7'b1000000, 1'b1);
        chk("reset_running", int'(running), 0, 1'b1);
        chk("reset_done", int'(done), 0, 1'b1);
        chk("reset_terminal", int'(terminal), 0, 1'b1);
        @(negedge clock_in);
        @(negedge clock_in) reset = 1'b0;
        checks_on = 1'b1;

        // Reset mid-run at count 9 takes effect without waiting for a clock edge.
        do_start();
        repeat (9) tick_pulse();
        chk("run_to_9", int'(count), 9, 1'b1);
        chk("run_running", int'(running), 1, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_count", int'(count), 0, 1'b1);
        chk("async_reset_running", int'(running), 0, 1'b1);
        chk("async_reset_seg", int'(seg), 7'b1000000, 1'b1);
        @(negedge clock_in) reset = 1'b0;

        // Up count with wrap: 1..15 then 0, single terminal on the 16th tick.
        do_start();
        t0 = term_seen;
        for (int k = 1; k <= 16; k++) begin
            tick_pulse();
            chk("wrap_count", int'(count), k % 16, 1'b1);
            if (k == 1)  chk("seg_1", int'(seg), 7'b1111001, 1'b1);
            if (k == 7)  chk("seg_7", int'(seg), 7'b1111000, 1'b1);
            if (k == 8)  chk("seg_8", int'(seg), 7'b0000000, 1'b1);
            if (k == 10) chk("seg_A", int'(seg), 7'b0001000, 1'b1);
            if (k == 15) chk("no_early_terminal", term_seen - t0, 0, 1'b1);
        end
        chk("wrap_terminal_once", term_seen - t0, 1, 1'b1);
        chk("wrap_still_running", int'(running), 1, 1'b1);

        // No wrap: terminal at 15, DONE holds, start reloads to 0.
        @(negedge clock_in) wrap_en = 1'b0;
        repeat (15) tick_pulse();
        chk("nowrap_at_15", int'(count), 15, 1'b1);
        t0 = term_seen;
        tick_pulse();
        chk("nowrap_terminal", term_seen - t0, 1, 1'b1);
        chk("nowrap_done", int'(done), 1, 1'b1);
        chk("nowrap_hold_15", int'(count), 15, 1'b1);
        tick_pulse();
        chk("done_ignores_tick", int'(count), 15, 1'b1);
        chk("done_no_terminal", term_seen - t0, 1, 1'b1);
        do_start();
        chk("restart_count", int'(count), 0, 1'b1);
        chk("restart_running", int'(running), 1, 1'b1);
        chk("restart_done", int'(done), 0, 1'b1);

        // Stop in the same cycle as a tick edge drops that tick.
        repeat (5) tick_pulse();
        chk("pre_stop_5", int'(count), 5, 1'b1);
        @(negedge clock_in) tick_in = 1'b1;
        @(negedge clock_in) stop = 1'b1;
        @(negedge clock_in) begin stop = 1'b0; tick_in = 1'b0; end
        @(negedge clock_in);
        @(negedge clock_in);
        chk("stop_drop_count", int'(count), 5, 1'b1);
        chk("pause_running", int'(running), 0, 1'b1);
        chk("pause_done", int'(done), 0, 1'b1);
        repeat (2) tick_pulse();
        chk("pause_hold", int'(count), 5, 1'b1);
        do_start();
        tick_pulse();
        chk("resume_6", int'(count), 6, 1'b1);

        // Long-held tick: one increment, landing on the second edge after the rise.
        @(negedge clock_in) tick_in = 1'b1;
        @(posedge clock_in); #1;
        chk("held_edge1", int'(count), 6, 1'b1);
        @(posedge clock_in); #1;
        chk("held_edge2", int'(count), 7, 1'b1);
        repeat (98) @(negedge clock_in);
        tick_in = 1'b0;
        repeat (3) @(negedge clock_in);
        chk("held_single_inc", int'(count), 7, 1'b1);

        // Clear while counting down reloads MAX_COUNT; then count down.
        @(negedge clock_in) up_down = 1'b0;
        do_clear();
        chk("clear_count", int'(count), 15, 1'b1);
        chk("clear_seg", int'(seg), 7'b0001110, 1'b1);
        chk("clear_running", int'(running), 0, 1'b1);
        do_start();
        tick_pulse();
        chk("down_14", int'(count), 14, 1'b1);

        repeat (2) @(negedge clock_in);
        checks_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
